// File: rtl/ps2_pkg.sv
// +----------------------------------------------------------------------+
// | ps2_pkg : shared types and constants for the PS/2 scan-code receiver |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK     = 8'hF0;
  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam int         PS2_DATA_BITS = 8;

endpackage

`default_nettype wire

// File: rtl/ps2_sync_filter.sv
// +----------------------------------------------------------------------+
// | ps2_sync_filter : 2-FF synchronizer plus FILTER_LEN stability filter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam logic [CW-1:0] c_cnt_last = CW'(FILTER_LEN - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_fall;

  // A new level is accepted only after it has differed for FILTER_LEN cycles in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      r_fall <= 1'b0;
      if (r_sync[1] != r_level) begin
        if (r_cnt == c_cnt_last) begin
          r_level <= r_sync[1];
          r_cnt   <= '0;
          r_fall  <= ~r_sync[1];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/ps2_scancode_rx.sv
// +----------------------------------------------------------------------+
// | ps2_scancode_rx : PS/2 frame receiver, strips break/extended codes   |
// | Optional macro PS2_PARITY_CHECK_EN enables odd-parity checking. R1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [3:0] o_dig1,
  output logic [3:0] o_dig2,
  output logic       o_key_valid,
  output logic       o_frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] c_timeout_max = TW'(TIMEOUT_CYC);
  localparam logic [2:0]    c_last_bit    = 3'(PS2_DATA_BITS - 1);

  logic w_clk_level;
  logic w_fall;
  logic w_data;
  logic w_stop_ok;

  ps2_state_t    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [TW-1:0] r_to_cnt;
  logic          r_brk;
  logic          r_ext;
  logic [3:0]    r_dig1;
  logic [3:0]    r_dig2;
  logic          r_key_valid;
  logic          r_frame_err;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk     (clk),
    .reset   (reset),
    .i_pin   (i_ps2_clk),
    .o_level (w_clk_level),
    .o_fall  (w_fall)
  );

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk     (clk),
    .reset   (reset),
    .i_pin   (i_ps2_data),
    .o_level (w_data),
    .o_fall  ()
  );

`ifdef PS2_PARITY_CHECK_EN
  logic r_parity;
  assign w_stop_ok = w_data & (^{r_shift, r_parity});
`else
  assign w_stop_ok = w_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_to_cnt    <= '0;
      r_brk       <= 1'b0;
      r_ext       <= 1'b0;
      r_dig1      <= '0;
      r_dig2      <= '0;
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_state == ST_IDLE || w_fall) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      // A fall landing on the timeout cycle wins; the frame keeps going.
      if (r_state != ST_IDLE && !w_fall && r_to_cnt == c_timeout_max) begin
        r_state     <= ST_IDLE;
        r_frame_err <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            if (!w_data) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            r_shift <= {w_data, r_shift[7:1]};
            if (r_bit_cnt == c_last_bit) begin
              r_state <= ST_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            r_parity <= w_data;
`endif
            r_state <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            if (!w_stop_ok) begin
              r_frame_err <= 1'b1;
            end else if (r_shift == PS2_BREAK) begin
              r_brk <= 1'b1;
            end else if (r_shift == PS2_EXT) begin
              r_ext <= 1'b1;
            end else if (r_brk || r_ext) begin
              r_brk <= 1'b0;
              r_ext <= 1'b0;
            end else begin
              r_dig2      <= r_shift[7:4];
              r_dig1      <= r_shift[3:0];
              r_key_valid <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_dig1      = r_dig1;
  assign o_dig2      = r_dig2;
  assign o_key_valid = r_key_valid;
  assign o_frame_err = r_frame_err;

  // The filtered clock level is only consumed through its fall strobe.
  logic w_unused;
  assign w_unused = w_clk_level;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scancode_rx.sv
// +----------------------------------------------------------------------+
// | tb_ps2_scancode_rx : scoreboard bench for ps2_scancode_rx            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ps2_scancode_rx;

  localparam int FL = 8;
  localparam int TO = 200;

  typedef struct packed {
    logic       is_err;
    logic [3:0] dig2;
    logic [3:0] dig1;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic       key_valid;
  logic       frame_err;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_data  (ps2_data),
    .o_dig1      (dig1),
    .o_dig2      (dig2),
    .o_key_valid (key_valid),
    .o_frame_err (frame_err)
  );

  // Monitor: every output event must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (key_valid || frame_err)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got valid=%0b err=%0b dig2=%h dig1=%h, required no event",
                 key_valid, frame_err, dig2, dig1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_err) begin
          if (!(frame_err && !key_valid)) begin
            errors++;
            $display("FAIL frame_err_event: got valid=%0b err=%0b, required valid=0 err=1",
                     key_valid, frame_err);
          end
        end else if (!(key_valid && !frame_err && dig2 == e.dig2 && dig1 == e.dig1)) begin
          errors++;
          $display("FAIL key_event: got valid=%0b err=%0b dig2=%h dig1=%h, required valid=1 err=0 dig2=%h dig1=%h",
                   key_valid, frame_err, dig2, dig1, e.dig2, e.dig1);
        end
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_key(input logic [7:0] b);
    exp_t e;
    e.is_err = 1'b0;
    e.dig2   = b[7:4];
    e.dig1   = b[3:0];
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e = '0;
    e.is_err = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par);
    logic p;
    p = (~^b) ^ flip_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(1'b1);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_dig1", dig1, 4'h0);
    check("reset_dig2", dig2, 4'h0);
    check("reset_key_valid", {3'b0, key_valid}, 4'h0);
    check("reset_frame_err", {3'b0, frame_err}, 4'h0);

    push_key(8'h1C);
    send_frame(8'h1C, 1'b0);

    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("break_hold_dig2", dig2, 4'h1);
    check("break_hold_dig1", dig1, 4'hC);
    push_key(8'h5A);
    send_frame(8'h5A, 1'b0);

    send_frame(8'hE0, 1'b0);
    send_frame(8'h5A, 1'b0);
    check("ext_hold_dig2", dig2, 4'h5);
    check("ext_hold_dig1", dig1, 4'hA);
    push_key(8'h24);
    send_frame(8'h24, 1'b0);

`ifdef PS2_PARITY_CHECK_EN
    push_err();
`else
    push_key(8'h1D);
`endif
    send_frame(8'h1D, 1'b1);

    push_err();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TO + 60) @(negedge clk);
    ps2_data = 1'b1;
    push_key(8'h4D);
    send_frame(8'h4D, 1'b0);

    // Short low glitch with data low: a real event would misalign the next frame.
    ps2_data = 1'b0;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (FL - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    push_key(8'h29);
    send_frame(8'h29, 1'b0);

    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ps2_data = 1'b1;
    @(negedge clk);
    check("midreset_dig1", dig1, 4'h0);
    check("midreset_dig2", dig2, 4'h0);
    check("midreset_key_valid", {3'b0, key_valid}, 4'h0);
    check("midreset_frame_err", {3'b0, frame_err}, 4'h0);
    repeat (30) @(negedge clk);
    push_key(8'h15);
    send_frame(8'h15, 1'b0);

    repeat (TO + 20) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
